// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MEM-stage data memory controller.
// Funct3 encodings, FSM state type and the alignment check.
package rv_mem_pkg;

    localparam int STATE_W = 2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [STATE_W-1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    // Unsupported encodings are reported as misaligned so they never reach the bus.
    function automatic logic misaligned(input logic [2:0] f3,
                                        input logic [1:0] a);
        logic m;
        case (f3)
            F3_LB, F3_LBU: m = 1'b0;
            F3_LH, F3_LHU: m = a[0];
            F3_LW:         m = (a != 2'b00);
            default:       m = 1'b1;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data memory req/ack bus between the MEM stage and the data memory.
// The stage is the master; the memory answers with a one-cycle ack.
interface mem_access_stage_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );

endinterface

// File: rtl/mem_access_stage_align.sv
// Byte-lane steering for stores and lane select plus extension for loads.
// Purely combinational; SB/SH/SW share the LB/LH/LW funct3 encodings.
module load_store_align
    import rv_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        be      = 4'b1111;
        wdata   = rs2;
        ld_data = rdata;
        case (funct3)
            F3_LB, F3_LBU: begin
                be      = 4'b0001 << addr_lo;
                wdata   = {4{rs2[7:0]}};
                ld_data = {{24{byte_sel[7] & ~funct3[2]}}, byte_sel};
            end
            F3_LH, F3_LHU: begin
                be      = 4'b0011 << {addr_lo[1], 1'b0};
                wdata   = {2{rs2[15:0]}};
                ld_data = {{16{half_sel[15] & ~funct3[2]}}, half_sel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage controller: issues data memory requests, stalls until ack or
// timeout, and presents aligned load data to the MEM/WB register.
module mem_access_stage
    import rv_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                EX_MEM_valid,
    input  logic                EX_MEM_memread,
    input  logic                EX_MEM_memwrite,
    input  logic [2:0]          EX_MEM_funct3,
    input  logic [31:0]         EX_MEM_ALU_result,
    input  logic [31:0]         EX_MEM_rs2_data,
    input  logic [4:0]          EX_MEM_rd,
    input  logic                EX_MEM_regwrite,
    input  logic                EX_MEM_memtoreg,
    mem_access_stage_if.master  dmem,
    output logic                mem_stall,
    output logic [31:0]         data_mem_read_data,
    output logic                MEM_regwrite,
    output logic [4:0]          MEM_rd,
    output logic                MEM_memtoreg,
    output logic [31:0]         MEM_ALU_result,
    output logic                mem_misalign,
    output logic                mem_bus_err
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [31:0] rdata_q, rdata_nxt;
    logic        err_q, err_nxt;
    logic        op, mis;
    logic        stall, misal;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_ld;

    assign op  = EX_MEM_valid & (EX_MEM_memread | EX_MEM_memwrite);
    assign mis = misaligned(EX_MEM_funct3, EX_MEM_ALU_result[1:0]);

    load_store_align u_align (
        .funct3  (EX_MEM_funct3),
        .addr_lo (EX_MEM_ALU_result[1:0]),
        .rs2     (EX_MEM_rs2_data),
        .rdata   (dmem.dmem_rdata),
        .be      (al_be),
        .wdata   (al_wdata),
        .ld_data (al_ld)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rdata_q <= rdata_nxt;
            err_q   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        rdata_nxt    = rdata_q;
        err_nxt      = err_q;
        stall        = 1'b0;
        misal        = 1'b0;
        MEM_regwrite = EX_MEM_regwrite;
        unique case (state)
            IDLE: begin
                if (op && !mis) begin
                    stall        = 1'b1;
                    MEM_regwrite = 1'b0;
                    cnt_nxt      = '0;
                    state_nxt    = WAIT;
                end else if (op) begin
                    misal        = 1'b1;
                    MEM_regwrite = 1'b0;
                end
            end
            WAIT: begin
                // MEM/WB keeps loading while stalled, so suppress writeback.
                stall        = 1'b1;
                MEM_regwrite = 1'b0;
                if (dmem.dmem_ack) begin
                    rdata_nxt = al_ld;
                    state_nxt = DONE;
                end else if (cnt == TO_LAST) begin
                    err_nxt   = 1'b1;
                    rdata_nxt = '0;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            DONE: begin
                MEM_regwrite = EX_MEM_regwrite & ~err_q;
                err_nxt      = 1'b0;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // EX/MEM is frozen by the stall, so the bus fields stay stable in WAIT.
    assign dmem.dmem_req   = (state == WAIT) & ~reset;
    assign dmem.dmem_we    = EX_MEM_memwrite;
    assign dmem.dmem_addr  = {EX_MEM_ALU_result[31:2], 2'b00};
    assign dmem.dmem_wdata = al_wdata;
    assign dmem.dmem_be    = EX_MEM_memwrite ? al_be : 4'b1111;

    assign mem_stall          = stall & ~reset;
    assign mem_misalign       = misal & ~reset;
    assign mem_bus_err        = err_q;
    assign data_mem_read_data = rdata_q;
    assign MEM_rd             = EX_MEM_rd;
    assign MEM_memtoreg       = EX_MEM_memtoreg;
    assign MEM_ALU_result     = EX_MEM_ALU_result;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage with a TIMEOUT_CYCLES=4 instance.
// A small bus responder acks a chosen number of WAIT cycles after request.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        EX_MEM_valid;
    logic        EX_MEM_memread;
    logic        EX_MEM_memwrite;
    logic [2:0]  EX_MEM_funct3;
    logic [31:0] EX_MEM_ALU_result;
    logic [31:0] EX_MEM_rs2_data;
    logic [4:0]  EX_MEM_rd;
    logic        EX_MEM_regwrite;
    logic        EX_MEM_memtoreg;
    logic        mem_stall;
    logic [31:0] data_mem_read_data;
    logic        MEM_regwrite;
    logic [4:0]  MEM_rd;
    logic        MEM_memtoreg;
    logic [31:0] MEM_ALU_result;
    logic        mem_misalign;
    logic        mem_bus_err;

    int checks   = 0;
    int failures = 0;
    int stalls;
    int reqs;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    mem_access_stage_if bus ();

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .EX_MEM_valid       (EX_MEM_valid),
        .EX_MEM_memread     (EX_MEM_memread),
        .EX_MEM_memwrite    (EX_MEM_memwrite),
        .EX_MEM_funct3      (EX_MEM_funct3),
        .EX_MEM_ALU_result  (EX_MEM_ALU_result),
        .EX_MEM_rs2_data    (EX_MEM_rs2_data),
        .EX_MEM_rd          (EX_MEM_rd),
        .EX_MEM_regwrite    (EX_MEM_regwrite),
        .EX_MEM_memtoreg    (EX_MEM_memtoreg),
        .dmem               (bus),
        .mem_stall          (mem_stall),
        .data_mem_read_data (data_mem_read_data),
        .MEM_regwrite       (MEM_regwrite),
        .MEM_rd             (MEM_rd),
        .MEM_memtoreg       (MEM_memtoreg),
        .MEM_ALU_result     (MEM_ALU_result),
        .mem_misalign       (mem_misalign),
        .mem_bus_err        (mem_bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic v, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] s);
        EX_MEM_valid      = v;
        EX_MEM_memread    = rd;
        EX_MEM_memwrite   = wr;
        EX_MEM_funct3     = f3;
        EX_MEM_ALU_result = a;
        EX_MEM_rs2_data   = s;
        EX_MEM_rd         = 5'd7;
        EX_MEM_regwrite   = rd;
        EX_MEM_memtoreg   = rd;
    endtask

    // Runs from IDLE until the first cycle without stall (DONE, or IDLE
    // when nothing was issued); ack_at < 0 means the memory never answers.
    task automatic do_access(input int ack_at, input logic [31:0] rd);
        int  w;
        bit  done;
        w      = 0;
        done   = 0;
        stalls = 0;
        reqs   = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (mem_stall) stalls++;
            if (bus.dmem_req) begin
                if (reqs == 0) begin
                    cap_addr  = bus.dmem_addr;
                    cap_wdata = bus.dmem_wdata;
                    cap_be    = bus.dmem_be;
                    cap_we    = bus.dmem_we;
                end
                reqs++;
                bus.dmem_ack   = (w == ack_at);
                bus.dmem_rdata = (w == ack_at) ? rd : 32'h0;
                w++;
            end else begin
                bus.dmem_ack   = 1'b0;
                bus.dmem_rdata = 32'h0;
            end
            if (!mem_stall) done = 1;
        end
        chk("bound", 32'(done), 32'd1);
    endtask

    initial begin
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 32'h0;
        reset = 1'b1;
        set_op(1, 1, 0, 3'b010, 32'h100, 32'h0);
        #3;
        chk("rst_req", 32'(bus.dmem_req), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_misal", 32'(mem_misalign), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_data", data_mem_read_data, 32'h0);
        chk("rst_err", 32'(mem_bus_err), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        do_access(0, 32'hDEADBEEF);
        chk("lw_stalls", stalls, 2);
        chk("lw_reqs", reqs, 1);
        chk("lw_addr", cap_addr, 32'h100);
        chk("lw_be", 32'(cap_be), 32'hF);
        chk("lw_we", 32'(cap_we), 32'd0);
        chk("lw_data", data_mem_read_data, 32'hDEADBEEF);
        chk("lw_regwr", 32'(MEM_regwrite), 32'd1);
        chk("lw_rd", 32'(MEM_rd), 32'd7);
        chk("lw_alu", MEM_ALU_result, 32'h100);
        chk("lw_m2r", 32'(MEM_memtoreg), 32'd1);

        @(posedge clk);
        #1 set_op(1, 1, 0, 3'b000, 32'h103, 32'h0);
        do_access(0, 32'h80FF0000);
        chk("lb_data", data_mem_read_data, 32'hFFFFFF80);

        @(posedge clk);
        #1 set_op(1, 1, 0, 3'b100, 32'h103, 32'h0);
        do_access(0, 32'h80FF0000);
        chk("lbu_data", data_mem_read_data, 32'h00000080);

        @(posedge clk);
        #1 set_op(1, 1, 0, 3'b101, 32'h102, 32'h0);
        do_access(1, 32'h80FF0000);
        chk("lhu_stalls", stalls, 3);
        chk("lhu_data", data_mem_read_data, 32'h000080FF);

        @(posedge clk);
        #1 set_op(1, 1, 0, 3'b001, 32'h100, 32'h0);
        do_access(0, 32'h12348001);
        chk("lh_data", data_mem_read_data, 32'hFFFF8001);

        @(posedge clk);
        #1 set_op(1, 0, 1, 3'b001, 32'h202, 32'h1234ABCD);
        do_access(2, 32'h0);
        chk("sh_stalls", stalls, 4);
        chk("sh_reqs", reqs, 3);
        chk("sh_be", 32'(cap_be), 32'hC);
        chk("sh_wdata", cap_wdata, 32'hABCDABCD);
        chk("sh_addr", cap_addr, 32'h200);
        chk("sh_we", 32'(cap_we), 32'd1);
        chk("sh_regwr", 32'(MEM_regwrite), 32'd0);

        @(posedge clk);
        #1 set_op(1, 0, 1, 3'b000, 32'h301, 32'h000000AB);
        do_access(0, 32'h0);
        chk("sb_be", 32'(cap_be), 32'h2);
        chk("sb_wdata", cap_wdata, 32'hABABABAB);
        chk("sb_addr", cap_addr, 32'h300);

        @(posedge clk);
        #1 set_op(1, 1, 0, 3'b010, 32'h101, 32'h0);
        do_access(0, 32'h0);
        chk("mis_stalls", stalls, 0);
        chk("mis_reqs", reqs, 0);
        chk("mis_flag", 32'(mem_misalign), 32'd1);
        chk("mis_regwr", 32'(MEM_regwrite), 32'd0);

        @(posedge clk);
        #1 set_op(1, 1, 0, 3'b011, 32'h100, 32'h0);
        @(negedge clk);
        chk("bad_f3", 32'(mem_misalign), 32'd1);
        chk("bad_f3_stall", 32'(mem_stall), 32'd0);

        @(posedge clk);
        #1 set_op(1, 1, 0, 3'b010, 32'h400, 32'h0);
        do_access(-1, 32'h0);
        chk("to_stalls", stalls, 5);
        chk("to_reqs", reqs, 4);
        chk("to_err", 32'(mem_bus_err), 32'd1);
        chk("to_data", data_mem_read_data, 32'h0);
        chk("to_regwr", 32'(MEM_regwrite), 32'd0);
        @(posedge clk);
        #1 set_op(0, 0, 0, 3'b010, 32'h0, 32'h0);
        @(negedge clk);
        chk("to_err_clr", 32'(mem_bus_err), 32'd0);
        chk("to_idle", 32'(mem_stall), 32'd0);

        // A stray ack while idle must leave the data register untouched.
        @(posedge clk);
        #1 bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("spur_req", 32'(bus.dmem_req), 32'd0);
        @(posedge clk);
        #1 bus.dmem_ack = 1'b0;
        @(negedge clk);
        chk("spur_data", data_mem_read_data, 32'h0);
        chk("spur_stall", 32'(mem_stall), 32'd0);

        @(posedge clk);
        #1 set_op(1, 1, 0, 3'b010, 32'h104, 32'h0);
        do_access(0, 32'h2468ACE0);
        chk("lw2_data", data_mem_read_data, 32'h2468ACE0);

        @(posedge clk);
        #1 set_op(1, 1, 0, 3'b010, 32'h108, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rw_req", 32'(bus.dmem_req), 32'd0);
        chk("rw_stall", 32'(mem_stall), 32'd0);
        @(negedge clk);
        chk("rw_data", data_mem_read_data, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        do_access(0, 32'h13579BDF);
        chk("rw_stalls", stalls, 2);
        chk("rw_new", data_mem_read_data, 32'h13579BDF);
        chk("rw_regwr", 32'(MEM_regwrite), 32'd1);

        @(posedge clk);
        #1 set_op(0, 0, 0, 3'b010, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage controller between the EX/MEM register and the MEM/WB register.
- Issues load/store requests to a data memory over a req/ack bus that may take several cycles.
- Stalls the pipeline until the memory responds, and aligns/extends sub-word load data.
- Drives the data_mem_read_data, MEM_regwrite, MEM_rd, MEM_memtoreg and MEM_ALU_result inputs of the MEM/WB register.

Parameters:
TIMEOUT_CYCLES, 16, number of WAIT cycles without dmem_ack before a bus error is declared (valid range 1..255).

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
EX_MEM_valid  input  1  EX/MEM holds a real instruction (not a bubble)
EX_MEM_memread  input  1  instruction is a load
EX_MEM_memwrite  input  1  instruction is a store
EX_MEM_funct3  input  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
EX_MEM_ALU_result  input  32  effective address, or ALU result for non-memory ops
EX_MEM_rs2_data  input  32  store data
EX_MEM_rd  input  5  destination register
EX_MEM_regwrite  input  1  writeback enable
EX_MEM_memtoreg  input  1  select load data for writeback
dmem_req  output  1  memory request, held until ack
dmem_we  output  1  1 = write
dmem_addr  output  32  word address ({addr[31:2],2'b00})
dmem_wdata  output  32  lane-replicated store data
dmem_be  output  4  byte enables (all 1111 on reads)
dmem_ack  input  1  one-cycle response strobe
dmem_rdata  input  32  read word, valid with dmem_ack
mem_stall  output  1  freeze PC, IF/ID, ID/EX and EX/MEM; MEM/WB loads normally
data_mem_read_data  output  32  aligned, extended load result
MEM_regwrite  output  1  gated writeback enable
MEM_rd  output  5  pass-through of EX_MEM_rd
MEM_memtoreg  output  1  pass-through of EX_MEM_memtoreg
MEM_ALU_result  output  32  pass-through of EX_MEM_ALU_result
mem_misalign  output  1  misaligned access flag (combinational, this instruction)
mem_bus_err  output  1  timeout flag (registered, valid in DONE)

Behaviour:
- **Definitions.**
  - op = EX_MEM_valid & (memread | memwrite).
  - Misaligned when: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Unsupported funct3 (011, 11x) is treated as misaligned.
- **FSM states:** IDLE, WAIT, DONE.
- **IDLE**
  - If op & aligned: mem_stall=1; next state WAIT; timeout counter cleared.
  - If op & misaligned: mem_misalign=1, no request, no stall, MEM_regwrite=0, stay IDLE.
  - Otherwise: zero-latency pass-through, mem_stall=0.
- **WAIT**
  - dmem_req=1, mem_stall=1, and dmem_we/addr/wdata/be are held stable.
  - On dmem_ack: capture dmem_rdata into the data register with lane select and extension; next state DONE.
  - Else if counter == TIMEOUT_CYCLES-1: set mem_bus_err, capture 0, next state DONE.
  - Else: counter+1.
- **DONE**
  - mem_stall=0, so MEM/WB latches this edge; next state IDLE.
  - MEM_regwrite = EX_MEM_regwrite & ~mem_bus_err.
  - mem_bus_err clears on leaving DONE.
- **Latency.** Ack in the first WAIT cycle gives 2 stall cycles; each extra ack delay adds 1.
- **Back-to-back ops.** Each takes a fresh IDLE→WAIT pass; there is no pipelining of requests.
- **Load extension.**
  - B/H: sign-extend.
  - BU/HU: zero-extend.
  - Lane selected by addr[1:0] (B) or addr[1] (H).
- **Store lanes.**
  - wdata replicates rs2[7:0] ×4 (B), rs2[15:0] ×2 (H), or rs2 (W).
  - be = 0001<<addr[1:0] (B), 0011<<{addr[1],1'b0} (H), or 1111 (W).
- **Spurious ack.** dmem_ack outside WAIT is ignored.
- **Reset values.**
  - State IDLE; counter 0; data register 0; mem_bus_err 0.
  - dmem_req, mem_stall and mem_misalign are 0 while reset is high.
- **Reset during WAIT.** dmem_req drops asynchronously and the in-flight access is abandoned.
- **Read data.** data_mem_read_data is the registered capture value; it is meaningful only in DONE.

Decomposition:
- Shared package rv_mem_pkg holds:
  - funct3 constants (F3_LB..F3_LHU);
  - the state enum {IDLE, WAIT, DONE};
  - a 2-bit state width constant.
- One natural sub-module: load_store_align. It is purely combinational and computes be/wdata from funct3, addr and rs2, and the extended load word from funct3, addr and rdata. The FSM and counter stay in mem_access_stage.

Test Plan:
- LW, addr 0x100, ack on first WAIT cycle, rdata 0xDEADBEEF → dmem_req high 1 cycle, mem_stall high 2 cycles, DONE shows data_mem_read_data=0xDEADBEEF, MEM_regwrite=1.
- LB addr 0x103 with rdata 0x80FF_0000, then LBU same → 0xFFFFFF80 then 0x00000080.
- SH addr 0x202, rs2 0x1234ABCD, ack after 3 cycles → dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_addr=0x200, 4 stall cycles.
- LW addr 0x101 → mem_misalign=1, dmem_req never asserts, mem_stall=0, MEM_regwrite=0.
- TIMEOUT_CYCLES=4, no ack → after 4 WAIT cycles DONE with mem_bus_err=1, data 0, MEM_regwrite=0, then IDLE.
- Assert reset in the 2nd WAIT cycle → dmem_req and mem_stall drop immediately; after release, state IDLE and a new LW completes normally.
